// File: rtl/capture_pkg.sv
// Shared types and defaults for the frame-capture sequencer.
package capture_pkg;

   localparam int COUNT_BITS_DEFAULT     = 8;
   localparam int GAP_BITS_DEFAULT       = 16;
   localparam int ARM_CYCLES_DEFAULT     = 2;
   localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      CAPTURE,
      GAP,
      ERROR
   } capture_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-register rising-edge detector; a level held high yields one pulse.
module rise_detect (
   input  logic clk_i,
   input  logic reset_i,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/capture_controller.sv
// Frame-capture sequencer: arms the sensor, counts frames, inserts gaps.
// Optional per-frame timeout enabled by defining FRAME_TIMEOUT_EN.
module capture_controller
   import capture_pkg::*;
#(
   parameter int COUNT_BITS     = COUNT_BITS_DEFAULT,
   parameter int GAP_BITS       = GAP_BITS_DEFAULT,
   parameter int ARM_CYCLES     = ARM_CYCLES_DEFAULT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  continuous_i,
   input  logic [COUNT_BITS-1:0] frame_count_i,
   input  logic [GAP_BITS-1:0]   gap_cycles_i,
   input  logic                  sensor_frame_finished_i,
   output logic                  sensor_reset_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic                  capture_done_o,
   output logic [COUNT_BITS-1:0] frames_captured_o,
   output logic                  error_o,
   output capture_state_e        state_o
);

   localparam int CNT_BITS = max_int(max_int(GAP_BITS, $clog2(TIMEOUT_CYCLES + 1)),
                                     $clog2(ARM_CYCLES + 1));
   localparam logic [CNT_BITS-1:0]   ARM_LOAD  = CNT_BITS'(ARM_CYCLES - 1);
   localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;
`ifdef FRAME_TIMEOUT_EN
   localparam logic [CNT_BITS-1:0]   TIMEOUT_LOAD = CNT_BITS'(TIMEOUT_CYCLES - 1);
`endif

   capture_state_e        state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [COUNT_BITS-1:0] remaining_q, remaining_d;
   logic [COUNT_BITS-1:0] frames_q, frames_d;
   logic [GAP_BITS-1:0]   gap_q, gap_d;
   logic                  cont_q, cont_d;
   logic                  stop_pending_q, stop_pending_d;
   logic                  sensor_reset_q, sensor_reset_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic                  capture_done_q, capture_done_d;
   logic                  start_ok;
   logic                  frame_edge;
`ifdef FRAME_TIMEOUT_EN
   logic                  error_q, error_d;
`endif

   rise_detect u_rise_detect (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .level_i (sensor_frame_finished_i),
      .rise_o  (frame_edge)
   );

   // cnt_q is one down-counter shared by the ARM hold, the GAP hold and the timeout.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      remaining_d    = remaining_q;
      frames_d       = frames_q;
      gap_d          = gap_q;
      cont_d         = cont_q;
      stop_pending_d = stop_pending_q;
      frame_done_d   = 1'b0;
      capture_done_d = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      error_d        = error_q;
`endif
      start_ok = start_i & ~stop_i & (continuous_i | (frame_count_i != '0));

      case (state_q)
         IDLE, ERROR: begin
            if (start_ok) begin
               state_d        = ARM;
               cnt_d          = ARM_LOAD;
               remaining_d    = frame_count_i;
               cont_d         = continuous_i;
               gap_d          = gap_cycles_i;
               frames_d       = '0;
               stop_pending_d = 1'b0;
`ifdef FRAME_TIMEOUT_EN
               error_d        = 1'b0;
`endif
            end
         end
         ARM: begin
            if (stop_i) begin
               state_d        = IDLE;
               capture_done_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = CAPTURE;
`ifdef FRAME_TIMEOUT_EN
               cnt_d   = TIMEOUT_LOAD;
`endif
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
            end
         end
         GAP: begin
            if (stop_i) begin
               state_d        = IDLE;
               capture_done_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ARM;
               cnt_d   = ARM_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
            end
         end
         CAPTURE: begin
            if (frame_edge) begin
               frame_done_d = 1'b1;
               if (frames_q != COUNT_MAX) frames_d = frames_q + COUNT_BITS'(1);
               if (!cont_q) remaining_d = remaining_q - COUNT_BITS'(1);
               // A stop arriving on the edge cycle still ends the run with this frame.
               if ((!cont_q && (remaining_q == COUNT_BITS'(1))) || stop_pending_q || stop_i) begin
                  state_d        = IDLE;
                  capture_done_d = 1'b1;
                  stop_pending_d = 1'b0;
               end else if (gap_q == '0) begin
                  state_d = ARM;
                  cnt_d   = ARM_LOAD;
               end else begin
                  state_d = GAP;
                  cnt_d   = CNT_BITS'(gap_q - GAP_BITS'(1));
               end
            end
`ifdef FRAME_TIMEOUT_EN
            else if (cnt_q == '0) begin
               state_d        = ERROR;
               error_d        = 1'b1;
               stop_pending_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
               if (stop_i) stop_pending_d = 1'b1;
            end
`else
            else if (stop_i) begin
               stop_pending_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      sensor_reset_d = (state_d != CAPTURE);
      busy_d         = (state_d != IDLE) && (state_d != ERROR);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         remaining_q    <= '0;
         frames_q       <= '0;
         gap_q          <= '0;
         cont_q         <= 1'b0;
         stop_pending_q <= 1'b0;
         sensor_reset_q <= 1'b1;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         capture_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         remaining_q    <= remaining_d;
         frames_q       <= frames_d;
         gap_q          <= gap_d;
         cont_q         <= cont_d;
         stop_pending_q <= stop_pending_d;
         sensor_reset_q <= sensor_reset_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         capture_done_q <= capture_done_d;
      end
   end

`ifdef FRAME_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end
   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

   assign sensor_reset_o    = sensor_reset_q;
   assign busy_o            = busy_q;
   assign frame_done_o      = frame_done_q;
   assign capture_done_o    = capture_done_q;
   assign frames_captured_o = frames_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed plus randomized checks of capture_controller against timeline arithmetic.
module tb_capture_controller;
   import capture_pkg::*;

   localparam int CB    = 8;
   localparam int GB    = 16;
   localparam int ARM_N = 2;
   localparam int TMO   = 20;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           stop;
   logic           continuous;
   logic [CB-1:0]  frame_count;
   logic [GB-1:0]  gap_cycles;
   logic           ffin;
   logic           sensor_reset;
   logic           busy;
   logic           frame_done;
   logic           capture_done;
   logic [CB-1:0]  frames_captured;
   logic           error;
   capture_state_e state;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int hold_sum;

   capture_controller #(
      .COUNT_BITS     (CB),
      .GAP_BITS       (GB),
      .ARM_CYCLES     (ARM_N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i                   (clk),
      .reset_i                 (reset),
      .start_i                 (start),
      .stop_i                  (stop),
      .continuous_i            (continuous),
      .frame_count_i           (frame_count),
      .gap_cycles_i            (gap_cycles),
      .sensor_frame_finished_i (ffin),
      .sensor_reset_o          (sensor_reset),
      .busy_o                  (busy),
      .frame_done_o            (frame_done),
      .capture_done_o          (capture_done),
      .frames_captured_o       (frames_captured),
      .error_o                 (error),
      .state_o                 (state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input bit cont, input int cnt, input int gap);
      continuous  = cont;
      frame_count = CB'(cnt);
      gap_cycles  = GB'(gap);
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   // Counts consecutive cycles with the sensor held in reset, from the current cycle on.
   task automatic wait_low(input string tag, input int exp_high);
      int n;
      n = 0;
      while (sensor_reset === 1'b1 && n < 1000) begin
         n++;
         step();
      end
      chk(tag, n, exp_high);
   endtask

   // Called in a CAPTURE cycle; waits delay cycles, then issues a one-cycle frame pulse.
   task automatic frame(input string tag, input int delay, input bit stop_first,
                        input int exp_cnt, input bit exp_last);
      for (int i = 0; i < delay; i++) begin
         if (i == 0 && stop_first) stop = 1'b1;
         step();
         stop = 1'b0;
         chk({tag, "_sr_low"}, sensor_reset, 0);
      end
      ffin = 1'b1;
      step();
      ffin = 1'b0;
      chk({tag, "_frame_done"}, frame_done, 1);
      chk({tag, "_count"}, frames_captured, exp_cnt);
      chk({tag, "_capture_done"}, capture_done, exp_last);
      chk({tag, "_busy"}, busy, !exp_last);
      chk({tag, "_sr_high"}, sensor_reset, 1);
   endtask

   task automatic run_random(input int iters);
      bit cont;
      int n;
      int g;
      int d;
      for (int it = 0; it < iters; it++) begin
         cont = 1'($urandom_range(0, 1));
         n    = $urandom_range(1, 4);
         g    = $urandom_range(0, 6);
         do_start(cont, cont ? int'($urandom_range(0, 255)) : n, g);
         chk("rnd_busy", busy, 1);
         wait_low("rnd_arm", ARM_N);
         for (int k = 1; k <= n; k++) begin
            if (k == n && cont) d = $urandom_range(1, 5);
            else d = $urandom_range(0, 5);
            frame("rnd", d, (k == n) && cont, k, k == n);
            if (k != n) wait_low("rnd_gap", g + 2);
         end
         chk("rnd_state_idle", 32'(state), 32'(IDLE));
         step();
         chk("rnd_done_pulse", capture_done, 0);
         chk("rnd_count_hold", frames_captured, n);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      frame_count = '0; gap_cycles = '0; ffin = 1'b0;
      repeat (3) step();
      chk("rst_sr", sensor_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_capture_done", capture_done, 0);
      chk("rst_count", frames_captured, 0);
      chk("rst_error", error, 0);
      chk("rst_state", 32'(state), 32'(IDLE));
      reset = 1'b0;
      step();

      // Two frames, no gap.
      do_start(0, 2, 0);
      chk("t1_busy", busy, 1);
      wait_low("t1_arm", ARM_N);
      frame("t1f1", 2, 0, 1, 0);
      wait_low("t1_rearm", ARM_N);
      frame("t1f2", 1, 0, 2, 1);
      chk("t1_idle", 32'(state), 32'(IDLE));
      step();
      chk("t1_done_pulse", capture_done, 0);
      chk("t1_count_hold", frames_captured, 2);

      // START while busy must not disturb the running sequence.
      do_start(0, 2, 3);
      wait_low("t2_arm", ARM_N);
      frame_count = CB'(9);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_busy_start_count", frames_captured, 0);
      chk("t2_busy_start_state", 32'(state), 32'(CAPTURE));
      frame("t2f1", 1, 0, 1, 0);
      wait_low("t2_gap", 3 + ARM_N);
      frame("t2f2", 2, 0, 2, 1);

      // Continuous with gap 5; STOP mid-capture lets the frame finish.
      do_start(1, 1, 5);
      wait_low("t3_arm", ARM_N);
      frame("t3f1", 0, 0, 1, 0);
      wait_low("t3_gap1", 5 + ARM_N);
      frame("t3f2", 2, 0, 2, 0);
      wait_low("t3_gap2", 5 + ARM_N);
      frame("t3f3", 3, 1, 3, 1);

      // Frame flag held high 10 cycles counts once.
      do_start(1, 0, 20);
      wait_low("t4_arm", ARM_N);
      ffin = 1'b1;
      step();
      hold_sum = int'(frame_done);
      repeat (9) begin
         step();
         hold_sum += int'(frame_done);
      end
      ffin = 1'b0;
      chk("t4_one_frame_done", hold_sum, 1);
      wait_low("t4_gap_rest", 22 - 9);
      stop = 1'b1;
      step();
      stop = 1'b0;
      frame("t4_end", 1, 0, 2, 1);

      // STOP during GAP.
      do_start(1, 0, 5);
      wait_low("t5_arm", ARM_N);
      frame("t5f1", 1, 0, 1, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_capture_done", capture_done, 1);
      chk("t5_sr", sensor_reset, 1);
      chk("t5_state", 32'(state), 32'(IDLE));

      // Ignored STARTs.
      do_start(0, 0, 0);
      chk("t6_zero_busy", busy, 0);
      chk("t6_zero_state", 32'(state), 32'(IDLE));
      continuous = 1'b0; frame_count = CB'(3); start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("t6_startstop_busy", busy, 0);
      chk("t6_startstop_count", frames_captured, 1);
      step();
      chk("t6_startstop_state", 32'(state), 32'(IDLE));

      // RESET during CAPTURE.
      do_start(0, 3, 0);
      wait_low("t7_arm", ARM_N);
      frame("t7f1", 1, 0, 1, 0);
      wait_low("t7_rearm", ARM_N);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t7_sr", sensor_reset, 1);
      chk("t7_busy", busy, 0);
      chk("t7_frame_done", frame_done, 0);
      chk("t7_capture_done", capture_done, 0);
      chk("t7_count", frames_captured, 0);
      step();
      chk("t7_state", 32'(state), 32'(IDLE));

      // Frame counter saturates at all-ones.
      do_start(1, 0, 0);
      wait_low("t8_arm", ARM_N);
      for (int k = 1; k <= 257; k++) begin
         frame("t8", (k == 257) ? 1 : 0, k == 257, (k > 255) ? 255 : k, k == 257);
         if (k != 257) wait_low("t8_rearm", ARM_N);
      end

      run_random(8);

`ifdef FRAME_TIMEOUT_EN
      do_start(0, 1, 0);
      wait_low("t9_arm", ARM_N);
      repeat (TMO - 1) step();
      chk("t9_pre_error", error, 0);
      step();
      chk("t9_error", error, 1);
      chk("t9_sr", sensor_reset, 1);
      chk("t9_busy", busy, 0);
      chk("t9_capture_done", capture_done, 0);
      chk("t9_state", 32'(state), 32'(ERROR));
      do_start(0, 1, 0);
      chk("t9_error_clear", error, 0);
      chk("t9_rearm_busy", busy, 1);
      wait_low("t9_arm2", ARM_N);
      frame("t9_edge_wins", TMO - 1, 0, 1, 1);
      chk("t9_no_error", error, 0);
`else
      do_start(0, 1, 0);
      wait_low("t9_arm", ARM_N);
      repeat (3 * TMO) step();
      chk("t9_still_capture", 32'(state), 32'(CAPTURE));
      chk("t9_no_error", error, 0);
      frame("t9_late", 0, 0, 1, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
